// File: rtl/alu_cnt_sched_if.sv
// Request/writeback bundle between the two ALU issue ports, the shared
// bit-count unit and the writeback stage.
interface alu_cnt_sched_if;
   logic        req0_valid_i;
   logic [6:0]  req0_uop_i;
   logic [31:0] req0_opnd_i;
   logic [5:0]  req0_dest_i;
   logic        req0_ready_o;

   logic        req1_valid_i;
   logic [6:0]  req1_uop_i;
   logic [31:0] req1_opnd_i;
   logic [5:0]  req1_dest_i;
   logic        req1_ready_o;

   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [5:0]  wb_dest_o;
   logic        wb_src_o;
   logic        wb_ready_i;

   modport master (
      output req0_valid_i, req0_uop_i, req0_opnd_i, req0_dest_i,
      output req1_valid_i, req1_uop_i, req1_opnd_i, req1_dest_i,
      output wb_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  wb_valid_o, wb_data_o, wb_dest_o, wb_src_o
   );

   modport slave (
      input  req0_valid_i, req0_uop_i, req0_opnd_i, req0_dest_i,
      input  req1_valid_i, req1_uop_i, req1_opnd_i, req1_dest_i,
      input  wb_ready_i,
      output req0_ready_o, req1_ready_o,
      output wb_valid_o, wb_data_o, wb_dest_o, wb_src_o
   );
endinterface

// File: rtl/alu_cnt_sched.sv
// Shared iterative CLZ/CTZ/CPOP unit (4 bits per cycle, 8 cycles) with a
// round-robin scheduler over two ALU issue ports and a held writeback result.
module alu_cnt_sched (
   input  logic           cpu_clock_i,
   input  logic           cpu_reset_n_i,
   input  logic           flush_i,
   output logic           busy_o,
   alu_cnt_sched_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {K_NONE, K_CLZ, K_CTZ, K_CPOP} kind_t;

   localparam logic [6:0] UOP_CLZ  = 7'b1101100;
   localparam logic [6:0] UOP_CTZ  = 7'b1101000;
   localparam logic [6:0] UOP_CPOP = 7'b1101011;

   function automatic kind_t decode(input logic [6:0] uop);
      kind_t k;
      k = K_NONE;
      case (uop)
         UOP_CLZ:  k = K_CLZ;
         UOP_CTZ:  k = K_CTZ;
         UOP_CPOP: k = K_CPOP;
         default:  k = K_NONE;
      endcase
      return k;
   endfunction

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic logic [5:0] lzc4(input logic [3:0] n);
      logic [5:0] c;
      casez (n)
         4'b1???: c = 6'd0;
         4'b01??: c = 6'd1;
         4'b001?: c = 6'd2;
         4'b0001: c = 6'd3;
         default: c = 6'd4;
      endcase
      return c;
   endfunction

   function automatic logic [5:0] pop4(input logic [3:0] n);
      return 6'(n[0]) + 6'(n[1]) + 6'(n[2]) + 6'(n[3]);
   endfunction

   state_t      state_q, state_d;
   logic        pri_q;
   kind_t       kind_q;
   logic [31:0] sh_q;
   logic [5:0]  acc_q, acc_d;
   logic        found_q, found_d;
   logic [2:0]  it_q;
   logic [5:0]  dest_q;
   logic        src_q;

   logic        gnt0, gnt1, accept;
   logic [6:0]  uop_sel;
   logic [31:0] opnd_sel;
   logic [5:0]  dest_sel;
   kind_t       kind_sel;
   logic [3:0]  nib;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (cpu_reset_n_i && state_q == S_IDLE && !flush_i) begin
         if (bus.req0_valid_i && bus.req1_valid_i) begin
            gnt0 = !pri_q;
            gnt1 = pri_q;
         end else begin
            gnt0 = bus.req0_valid_i;
            gnt1 = bus.req1_valid_i;
         end
      end
   end

   assign accept   = gnt0 | gnt1;
   assign uop_sel  = gnt1 ? bus.req1_uop_i  : bus.req0_uop_i;
   assign opnd_sel = gnt1 ? bus.req1_opnd_i : bus.req0_opnd_i;
   assign dest_sel = gnt1 ? bus.req1_dest_i : bus.req0_dest_i;
   assign kind_sel = decode(uop_sel);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (it_q == 3'd7) state_d = S_DONE;
         S_DONE:  if (bus.wb_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Flush beats everything, including a result being taken this cycle.
      if (flush_i) state_d = S_IDLE;
   end

   assign nib = sh_q[31:28];

   // CTZ arrives bit-reversed, so it shares the leading-zero walk with CLZ;
   // found freezes the sum once the first set bit has been passed.
   always_comb begin
      acc_d   = acc_q;
      found_d = found_q;
      case (kind_q)
         K_CPOP: acc_d = acc_q + pop4(nib);
         K_CLZ, K_CTZ: begin
            if (!found_q) begin
               acc_d   = acc_q + lzc4(nib);
               found_d = |nib;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         state_q <= S_IDLE;
         pri_q   <= 1'b0;
         kind_q  <= K_NONE;
         sh_q    <= '0;
         acc_q   <= '0;
         found_q <= 1'b0;
         it_q    <= '0;
         dest_q  <= '0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pri_q   <= ~gnt1;
            kind_q  <= kind_sel;
            sh_q    <= (kind_sel == K_CTZ) ? bit_rev(opnd_sel) : opnd_sel;
            acc_q   <= '0;
            found_q <= 1'b0;
            it_q    <= '0;
            dest_q  <= dest_sel;
            src_q   <= gnt1;
         end else if (state_q == S_RUN) begin
            acc_q   <= acc_d;
            found_q <= found_d;
            sh_q    <= {sh_q[27:0], 4'b0000};
            it_q    <= it_q + 3'd1;
         end
      end
   end

   assign bus.req0_ready_o = gnt0;
   assign bus.req1_ready_o = gnt1;

   assign busy_o         = (state_q != S_IDLE);
   assign bus.wb_valid_o = (state_q == S_DONE);
   assign bus.wb_data_o  = bus.wb_valid_o ? {26'b0, acc_q} : 32'b0;
   assign bus.wb_dest_o  = bus.wb_valid_o ? dest_q : 6'b0;
   assign bus.wb_src_o   = bus.wb_valid_o & src_q;

endmodule

// File: tb/tb_alu_cnt_sched.sv
// Self-checking bench for alu_cnt_sched: directed vector table, multi-cycle
// corner sequences, and random uops against a plain-arithmetic count model.
module tb_alu_cnt_sched;

   localparam logic [6:0] CLZ  = 7'b1101100;
   localparam logic [6:0] CTZ  = 7'b1101000;
   localparam logic [6:0] CPOP = 7'b1101011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   alu_cnt_sched_if bus ();

   alu_cnt_sched dut (
      .cpu_clock_i   (clk),
      .cpu_reset_n_i (rst_n),
      .flush_i       (flush),
      .busy_o        (busy),
      .bus           (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          port;
      logic [6:0]  uop;
      logic [31:0] opnd;
      logic [5:0]  dest;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: count straight from the operand bits.
   function automatic logic [31:0] ref_count(input logic [6:0] uop, input logic [31:0] v);
      int r;
      r = 0;
      if (uop == CLZ) begin
         r = 32;
         for (int i = 0; i < 32; i++) if (v[i]) r = 31 - i;
      end else if (uop == CTZ) begin
         r = 32;
         for (int i = 31; i >= 0; i--) if (v[i]) r = i;
      end else if (uop == CPOP) begin
         r = $countones(v);
      end
      return 32'(r);
   endfunction

   task automatic set_req(input bit port, input bit v, input logic [6:0] uop,
                          input logic [31:0] opnd, input logic [5:0] dest);
      if (port == 1'b0) begin
         bus.req0_valid_i = v; bus.req0_uop_i = uop;
         bus.req0_opnd_i  = opnd; bus.req0_dest_i = dest;
      end else begin
         bus.req1_valid_i = v; bus.req1_uop_i = uop;
         bus.req1_opnd_i  = opnd; bus.req1_dest_i = dest;
      end
   endtask

   // Returns inside the accept cycle (between its negedge and the closing posedge).
   task automatic wait_accept(input bit port, output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if ((port ? bus.req1_ready_o : bus.req0_ready_o) === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Called in cycle T+1; lat = k means wb_valid first seen in cycle T+k.
   task automatic wait_wb(output int lat, output bit busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         #1;
         if (bus.wb_valid_o === 1'b1) begin
            lat = k;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input bit port, input logic [6:0] uop, input logic [31:0] opnd,
                         input logic [5:0] dest, input logic [31:0] exp, input string tag);
      bit got, busy_ok;
      int lat;
      set_req(port, 1'b1, uop, opnd, dest);
      wait_accept(port, got);
      check({tag, "_accept"}, 32'(got), 32'd1);
      if (!got) begin
         set_req(port, 1'b0, uop, opnd, dest);
         return;
      end
      @(negedge clk);
      set_req(port, 1'b0, uop, opnd, dest);
      wait_wb(lat, busy_ok);
      check({tag, "_latency"}, 32'(lat), 32'd9);
      check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
      check({tag, "_data"}, bus.wb_data_o, exp);
      check({tag, "_dest"}, 32'(bus.wb_dest_o), 32'(dest));
      check({tag, "_src"}, 32'(bus.wb_src_o), 32'(port));
      @(negedge clk);
      #1;
      check({tag, "_released"}, {30'b0, bus.wb_valid_o, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      bit got, busy_ok, stable, both;
      int lat;
      int gport [4];
      int gcyc [4];
      int ng;
      logic [31:0] hold_data;
      logic [5:0]  hold_dest;
      logic [6:0]  ru;
      logic [31:0] ro;

      set_req(1'b0, 1'b0, 7'h0, 32'h0, 6'h0);
      set_req(1'b1, 1'b0, 7'h0, 32'h0, 6'h0);
      bus.wb_ready_i = 1'b1;

      vecs[0]  = '{1'b0, CLZ,  32'h0000_0F00, 6'd12, 32'd20};
      vecs[1]  = '{1'b1, CTZ,  32'h0000_0000, 6'd40, 32'd32};
      vecs[2]  = '{1'b1, CTZ,  32'h8000_0000, 6'd41, 32'd31};
      vecs[3]  = '{1'b1, CPOP, 32'hFFFF_FFFF, 6'd42, 32'd32};
      vecs[4]  = '{1'b1, CPOP, 32'h1234_5678, 6'd43, 32'd13};
      vecs[5]  = '{1'b0, CLZ,  32'h0000_0000, 6'd1,  32'd32};
      vecs[6]  = '{1'b0, CLZ,  32'h0000_0001, 6'd2,  32'd31};
      vecs[7]  = '{1'b0, CTZ,  32'h0000_0001, 6'd3,  32'd0};
      vecs[8]  = '{1'b1, CLZ,  32'h8000_0000, 6'd63, 32'd0};
      vecs[9]  = '{1'b0, CTZ,  32'h00F0_0000, 6'd17, 32'd20};
      vecs[10] = '{1'b1, 7'h33, 32'h0000_FFFF, 6'd18, 32'd0};

      // Reset state with no requests pending.
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      check("rst_wb_data", bus.wb_data_o, 32'd0);
      check("rst_wb_dest", 32'(bus.wb_dest_o), 32'd0);
      check("rst_wb_src", 32'(bus.wb_src_o), 32'd0);
      check("rst_ready", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].port, vecs[i].uop, vecs[i].opnd, vecs[i].dest, vecs[i].exp,
                $sformatf("vec%0d", i));

      // Round robin: both ports valid continuously from reset.
      @(negedge clk);
      do_reset();
      set_req(1'b0, 1'b1, CLZ,  32'h0000_0F00, 6'd5);
      set_req(1'b1, 1'b1, CPOP, 32'h1234_5678, 6'd9);
      ng = 0;
      both = 1'b0;
      for (int i = 0; i < 80 && ng < 4; i++) begin
         #1;
         if (bus.req0_ready_o && bus.req1_ready_o) both = 1'b1;
         if (bus.req0_ready_o || bus.req1_ready_o) begin
            gport[ng] = bus.req1_ready_o ? 1 : 0;
            gcyc[ng]  = cyc;
            ng++;
         end
         if (bus.wb_valid_o)
            check("rr_data", bus.wb_data_o, bus.wb_src_o ? 32'd13 : 32'd20);
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, CLZ, 32'h0, 6'd0);
      set_req(1'b1, 1'b0, CPOP, 32'h0, 6'd0);
      check("rr_grants", 32'(ng), 32'd4);
      check("rr_both_ready", 32'(both), 32'd0);
      if (ng == 4) begin
         check("rr_order", 32'({gport[0][0], gport[1][0], gport[2][0], gport[3][0]}), 32'b0101);
         for (int i = 1; i < 4; i++)
            check($sformatf("rr_spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd10);
      end
      for (int i = 0; i < 12; i++) @(negedge clk);

      // Writeback stall while port 1 waits.
      bus.wb_ready_i = 1'b0;
      set_req(1'b0, 1'b1, CPOP, 32'hF0F0_F0F0, 6'd33);
      wait_accept(1'b0, got);
      check("stall_accept", 32'(got), 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, CPOP, 32'h0, 6'd0);
      set_req(1'b1, 1'b1, CLZ, 32'h0001_0000, 6'd7);
      wait_wb(lat, busy_ok);
      check("stall_latency", 32'(lat), 32'd9);
      check("stall_data", bus.wb_data_o, 32'd16);
      hold_data = bus.wb_data_o;
      hold_dest = bus.wb_dest_o;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== hold_data ||
             bus.wb_dest_o !== hold_dest || bus.req1_ready_o !== 1'b0)
            stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 32'd1);
      check("stall_dest", 32'(hold_dest), 32'd33);
      @(negedge clk);
      bus.wb_ready_i = 1'b1;
      #1;
      check("release_no_same_cycle_grant", 32'(bus.req1_ready_o), 32'd0);
      check("release_wb_valid", 32'(bus.wb_valid_o), 32'd1);
      @(negedge clk);
      #1;
      check("release_idle", 32'(busy), 32'd0);
      check("release_grant", 32'(bus.req1_ready_o), 32'd1);
      run_op(1'b1, CLZ, 32'h0001_0000, 6'd7, 32'd15, "after_stall");

      // Flush at RUN iteration 3 (pri is 0 here, grant to port 0 moves it to 1).
      set_req(1'b0, 1'b1, CLZ, 32'h0000_FFFF, 6'd11);
      wait_accept(1'b0, got);
      check("flush_run_accept", 32'(got), 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, CLZ, 32'h0, 6'd0);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_run_idle", {30'b0, bus.wb_valid_o, busy}, 32'd0);
      set_req(1'b0, 1'b1, CTZ, 32'h0000_0010, 6'd20);
      set_req(1'b1, 1'b1, CTZ, 32'h8000_0000, 6'd21);
      #1;
      check("flush_run_pri", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'b10);
      flush = 1'b1;
      #1;
      check("flush_idle_ready", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'b00);
      @(negedge clk);
      flush = 1'b0;
      set_req(1'b0, 1'b0, CTZ, 32'h0, 6'd0);

      // Flush during DONE with wb_ready high (grant to port 1 moves pri to 0).
      wait_accept(1'b1, got);
      check("flush_done_accept", 32'(got), 32'd1);
      @(negedge clk);
      set_req(1'b1, 1'b0, CTZ, 32'h0, 6'd0);
      wait_wb(lat, busy_ok);
      check("flush_done_latency", 32'(lat), 32'd9);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_done_idle", {30'b0, bus.wb_valid_o, busy}, 32'd0);
      set_req(1'b0, 1'b1, CLZ, 32'h0, 6'd0);
      set_req(1'b1, 1'b1, CLZ, 32'h0, 6'd0);
      #1;
      check("flush_done_pri", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'b01);
      set_req(1'b0, 1'b0, CLZ, 32'h0, 6'd0);
      set_req(1'b1, 1'b0, CLZ, 32'h0, 6'd0);
      @(negedge clk);

      // Asynchronous reset mid-RUN; port 0 grant leaves pri at 1 beforehand.
      set_req(1'b0, 1'b1, CPOP, 32'hFFFF_FFFF, 6'd50);
      wait_accept(1'b0, got);
      check("arst_accept", 32'(got), 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, CPOP, 32'h0, 6'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {bus.wb_data_o[29:0], bus.wb_valid_o, busy}, 32'd0);
      check("arst_dest", 32'(bus.wb_dest_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1'b0, 1'b1, 7'h00, 32'hDEAD_BEEF, 6'd22);
      set_req(1'b1, 1'b1, CLZ, 32'h0, 6'd0);
      #1;
      check("arst_pri", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'b01);
      set_req(1'b1, 1'b0, CLZ, 32'h0, 6'd0);
      run_op(1'b0, 7'h00, 32'hDEAD_BEEF, 6'd22, 32'd0, "arst_add");

      // Random uops against the reference model.
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: ru = CLZ;
            1: ru = CTZ;
            2: ru = CPOP;
            default: ru = 7'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: ro = 32'h0;
            1: ro = 32'hFFFF_FFFF;
            2: ro = 32'h1 << $urandom_range(0, 31);
            3: ro = $urandom >> $urandom_range(0, 31);
            default: ro = $urandom;
         endcase
         run_op(1'($urandom), ru, ro, 6'($urandom), ref_count(ru, ro), $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
